// File: rtl/wu_fetch_pkg.sv
// Shared definitions for the work-unit fetch controller: memory geometry,
// FSM state encoding and the program-counter wrap helper.
package wu_fetch_pkg;

    localparam int MGR_INSTRUCTION_MEMORY_DEPTH = 16;
    localparam int MGR_WU_ADDR_WIDTH            = $clog2(MGR_INSTRUCTION_MEMORY_DEPTH);

    typedef enum logic [1:0] {
        WUF_IDLE  = 2'd0,
        WUF_FETCH = 2'd1,
        WUF_DRAIN = 2'd2
    } wuf_state_e;

    // Next sequential instruction address, wrapping at the memory depth.
    function automatic logic [MGR_WU_ADDR_WIDTH-1:0] wuf_next_pc(
        input logic [MGR_WU_ADDR_WIDTH-1:0] pc,
        input int                           depth
    );
        if (int'(pc) == depth - 1) begin
            return {MGR_WU_ADDR_WIDTH{1'b0}};
        end else begin
            return pc + MGR_WU_ADDR_WIDTH'(1);
        end
    endfunction

endpackage

// File: rtl/wu_fetch_credit_cntr.sv
// Credit counter bounding reads in flight to the decode buffer depth; flags a
// consume that arrives when no read is outstanding.
module wu_fetch_credit_cntr #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue,
    input  logic          consume,
    input  logic          enable,
    input  logic          init,
    output logic [CW-1:0] credits,
    output logic          full,
    output logic          empty,
    output logic          underflow_err
);

    assign full  = (credits == CW'(MAX));
    assign empty = (credits == {CW{1'b0}});

    // Credit bookkeeping; simultaneous issue and consume cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits       <= CW'(MAX);
            underflow_err <= 1'b0;
        end else if (init) begin
            credits <= CW'(MAX);
        end else if (enable) begin
            case ({issue, consume})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    // A consume with nothing outstanding saturates and latches the error.
                    if (full) begin
                        underflow_err <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: credits <= credits;
            endcase
        end else begin
            credits <= credits;
        end
    end

endmodule

// File: rtl/wu_fetch.sv
// Work-unit instruction fetch controller: streams reads from a start address,
// throttled by decode credits, and drains outstanding reads after halt.
module wu_fetch
    import wu_fetch_pkg::*;
#(
    parameter int WUF_MAX_OUTSTANDING = 4,
    parameter int WUF_MEM_DEPTH       = MGR_INSTRUCTION_MEMORY_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_poweron,
    input  logic                         sys__wuf__start,
    input  logic [MGR_WU_ADDR_WIDTH-1:0] sys__wuf__start_addr,
    output logic                         wuf__sys__busy,
    output logic                         wuf__sys__done,
    output logic                         wuf__sys__credit_err,
    input  logic                         wum__wuf__stall,
    output logic [MGR_WU_ADDR_WIDTH-1:0] wuf__wum__addr,
    output logic                         wuf__wum__read,
    input  logic                         wud__wuf__consume,
    input  logic                         wud__wuf__halt
);

    localparam int CW = $clog2(WUF_MAX_OUTSTANDING + 1);
    localparam int AW = MGR_WU_ADDR_WIDTH;

    wuf_state_e     state_r;
    logic [AW-1:0]  pc_r;
    logic [CW-1:0]  credits_s;
    logic           full_s;
    logic           empty_s;
    logic           issue_s;
    logic           init_s;
    logic           enable_s;

    // Halt wins over an otherwise eligible read so nothing past it is fetched that cycle.
    assign issue_s  = (state_r == WUF_FETCH) && !wum__wuf__stall && !empty_s && !wud__wuf__halt;
    assign init_s   = (state_r == WUF_IDLE) && sys__wuf__start;
    assign enable_s = (state_r != WUF_IDLE);

    wu_fetch_credit_cntr #(
        .MAX (WUF_MAX_OUTSTANDING),
        .CW  (CW)
    ) u_credit (
        .clk           (clk),
        .reset         (reset_poweron),
        .issue         (issue_s),
        .consume       (wud__wuf__consume),
        .enable        (enable_s),
        .init          (init_s),
        .credits       (credits_s),
        .full          (full_s),
        .empty         (empty_s),
        .underflow_err (wuf__sys__credit_err)
    );

    // Fetch FSM with program counter and registered memory/system outputs.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_r        <= WUF_IDLE;
            pc_r           <= {AW{1'b0}};
            wuf__wum__addr <= {AW{1'b0}};
            wuf__wum__read <= 1'b0;
            wuf__sys__busy <= 1'b0;
            wuf__sys__done <= 1'b0;
        end else begin
            wuf__wum__read <= 1'b0;
            wuf__sys__done <= 1'b0;
            case (state_r)
                WUF_IDLE: begin
                    if (sys__wuf__start) begin
                        state_r        <= WUF_FETCH;
                        pc_r           <= sys__wuf__start_addr;
                        wuf__sys__busy <= 1'b1;
                    end else begin
                        wuf__sys__busy <= 1'b0;
                    end
                end
                WUF_FETCH: begin
                    if (issue_s) begin
                        wuf__wum__read <= 1'b1;
                        wuf__wum__addr <= pc_r;
                        pc_r           <= wuf_next_pc(pc_r, WUF_MEM_DEPTH);
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (wud__wuf__halt) begin
                        state_r <= WUF_DRAIN;
                    end else begin
                        state_r <= WUF_FETCH;
                    end
                end
                WUF_DRAIN: begin
                    // All credits home means every read, speculative or not, was consumed.
                    if (full_s) begin
                        state_r        <= WUF_IDLE;
                        wuf__sys__busy <= 1'b0;
                        wuf__sys__done <= 1'b1;
                    end else begin
                        state_r <= WUF_DRAIN;
                    end
                end
                default: begin
                    state_r        <= WUF_IDLE;
                    wuf__sys__busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wu_fetch.sv
// Self-checking bench for wu_fetch: directed phases plus randomized traffic,
// compared cycle by cycle against a transaction-level model of the fetcher.
module tb_wu_fetch;

    localparam int MAX   = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset_poweron;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          busy;
    logic          done;
    logic          credit_err;
    logic          stall;
    logic [AW-1:0] addr;
    logic          read;
    logic          consume;
    logic          halt;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 fetching, 2 draining; m_outst counts reads not yet consumed.
    int m_mode  = 0;
    int m_outst = 0;
    int m_next  = 0;
    int m_addr  = 0;
    bit m_read  = 1'b0;
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;

    bit [7:0] hist   = 8'd0;
    bit       auto_c = 1'b0;
    int       cdelay = 2;

    wu_fetch dut (
        .clk                  (clk),
        .reset_poweron        (reset_poweron),
        .sys__wuf__start      (start),
        .sys__wuf__start_addr (start_addr),
        .wuf__sys__busy       (busy),
        .wuf__sys__done       (done),
        .wuf__sys__credit_err (credit_err),
        .wum__wuf__stall      (stall),
        .wuf__wum__addr       (addr),
        .wuf__wum__read       (read),
        .wud__wuf__consume    (consume),
        .wud__wuf__halt       (halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit st, input int sa, input bit stl,
                         input bit hlt, input bit c);
        int pre;
        bit iss;
        pre = m_outst;
        iss = 1'b0;
        m_read = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_mode = 0; m_outst = 0; m_next = 0; m_addr = 0; m_err = 1'b0;
        end else if (m_mode == 0) begin
            if (st) begin
                m_mode = 1;
                m_next = sa;
                m_outst = 0;
            end
        end else begin
            if (m_mode == 1) begin
                iss = !stl && (pre < MAX) && !hlt;
                if (iss) begin
                    m_read = 1'b1;
                    m_addr = m_next;
                    m_next = (m_next + 1) % DEPTH;
                end
                if (hlt) m_mode = 2;
            end else if (pre == 0) begin
                m_mode = 0;
                m_done = 1'b1;
            end
            if (c && !iss) begin
                if (pre == 0) m_err = 1'b1;
                else m_outst = pre - 1;
            end else if (iss && !c) begin
                m_outst = pre + 1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit st, input int sa, input bit stl,
                        input bit hlt, input bit xcons);
        bit c;
        c = xcons | (auto_c & hist[cdelay-1]);
        reset_poweron = rst;
        start         = st;
        start_addr    = AW'(sa);
        stall         = stl;
        halt          = hlt;
        consume       = c;
        @(posedge clk);
        model(rst, st, sa, stl, hlt, c);
        hist = {hist[6:0], m_read};
        #1;
        check("read", 32'(read), 32'(m_read));
        check("addr", 32'(addr), 32'(m_addr));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("done", 32'(done), 32'(m_done));
        check("credit_err", 32'(credit_err), 32'(m_err));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with stall high, as the memory presents it.
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 9, 1'b1, 1'b1, 1'b1);

        // Basic streaming from 5 with consumes two cycles after each read; a mid-run start is ignored.
        hist = 8'd0; auto_c = 1'b1; cdelay = 2;
        step(1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        idle_steps(5);
        step(1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        idle_steps(5);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle_steps(8);

        // Credit limit: four reads, then one more per returned credit; drain by hand.
        hist = 8'd0; auto_c = 1'b0;
        step(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle_steps(7);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle_steps(3);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle_steps(3);

        // Address wrap from 14, halting on an eligible cycle.
        hist = 8'd0; auto_c = 1'b1; cdelay = 2;
        step(1'b0, 1'b1, 14, 1'b0, 1'b0, 1'b0);
        idle_steps(5);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle_steps(8);

        // Halt with nothing outstanding: one drain cycle, then done.
        step(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        idle_steps(3);

        // Randomized traffic, then hold halt until everything drains.
        hist = 8'd0; auto_c = 1'b1; cdelay = 3;
        for (int i = 0; i < 400; i++) begin
            step(1'b0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Consume in IDLE is harmless; an extra consume in FETCH latches the error.
        hist = 8'd0; auto_c = 1'b0;
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Reset mid-FETCH, stragglers land in IDLE, then a clean restart.
        hist = 8'd0; auto_c = 1'b1; cdelay = 2;
        idle_steps(4);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle_steps(4);
        step(1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0);
        idle_steps(6);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle_steps(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
